// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: frames start/data/parity/stop bits on an
// oversampled clock and drives the sampler/deserializer strobes.
// Optional parity support is compiled in with the macro UART_RX_PARITY_EN;
// without it there is no PARITY state and par_err stays 0.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    input  logic [DATA_WIDTH-1:0] P_Data,
    output logic [5:0]            edge_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int unsigned EDGE_W = 6;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    state_t              state_q, state_n;
    logic [EDGE_W-1:0]   edge_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic [EDGE_W-1:0]   pre_q, pre_n;
    logic [EDGE_W-1:0]   last_idx, last_idx_n;
    logic                at_last;
    logic                par_err_n, stp_err_n;
    logic                deser_en_n, samp_en_n, valid_n;

`ifdef UART_RX_PARITY_EN
    logic                par_en_q, par_en_n;
    logic                par_typ_q, par_typ_n;
`else
    logic                cfg_unused;
    assign cfg_unused = ^{PAR_EN, PAR_TYP, P_Data};
`endif

    // State, counters, latched frame config and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            edge_cnt    <= '0;
            bit_q       <= '0;
            pre_q       <= '0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            deser_en    <= 1'b0;
            dat_samp_en <= 1'b0;
            data_valid  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            edge_cnt    <= edge_n;
            bit_q       <= bit_n;
            pre_q       <= pre_n;
            par_err     <= par_err_n;
            stp_err     <= stp_err_n;
            deser_en    <= deser_en_n;
            dat_samp_en <= samp_en_n;
            data_valid  <= valid_n;
`ifdef UART_RX_PARITY_EN
            par_en_q    <= par_en_n;
            par_typ_q   <= par_typ_n;
`endif
        end
    end

    // Next-state, counter and strobe decode; bit decisions happen on the last edge
    always_comb begin
        state_n    = state_q;
        edge_n     = edge_cnt;
        bit_n      = bit_q;
        pre_n      = pre_q;
        par_err_n  = par_err;
        stp_err_n  = stp_err;
`ifdef UART_RX_PARITY_EN
        par_en_n   = par_en_q;
        par_typ_n  = par_typ_q;
`else
        par_err_n  = 1'b0;
`endif
        last_idx   = pre_q - EDGE_W'(1);
        at_last    = (edge_cnt == last_idx);

        if (state_q != IDLE) begin
            edge_n = at_last ? '0 : edge_cnt + EDGE_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_n   = START;
                    edge_n    = '0;
                    pre_n     = Prescale;
                    par_err_n = 1'b0;
                    stp_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_en_n  = PAR_EN;
                    par_typ_n = PAR_TYP;
`endif
                end
            end
            START: begin
                if (at_last) begin
                    if (sampled_bit) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
            end
            DATA: begin
                if (at_last) begin
                    if (bit_q == LAST_BIT) begin
                        bit_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = par_en_q ? PARITY : STOP;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_last) begin
                    par_err_n = par_typ_q ? (sampled_bit != ~^P_Data)
                                          : (sampled_bit != ^P_Data);
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (at_last) begin
                    stp_err_n = ~sampled_bit;
                    state_n   = OUTPUT;
                end
            end
            OUTPUT: begin
                // OUTPUT doubles as the first edge of a back-to-back start bit
                if (!RX_IN) begin
                    state_n   = START;
                    pre_n     = Prescale;
                    par_err_n = 1'b0;
                    stp_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_en_n  = PAR_EN;
                    par_typ_n = PAR_TYP;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n == IDLE) begin
            edge_n = '0;
        end

        last_idx_n = pre_n - EDGE_W'(1);
        deser_en_n = (state_n == DATA) && (edge_n == last_idx_n);
        samp_en_n  = (state_n != IDLE);
        valid_n    = (state_n == OUTPUT) && !par_err_n && !stp_err_n;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: directed frames with a simple sampler
// and deserializer model; a negedge monitor checks each completed frame.
module tb_uart_rx_fsm;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          sampled_bit;
    logic [DW-1:0] P_Data;
    logic [5:0]    edge_cnt;
    logic          dat_samp_en;
    logic          deser_en;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       se;
        int         pre;
        int         gap;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   pulse_total = 0;
    int   last_pulse_cyc = 0;
    int   last_dv_cyc = -1;
    int   wait_cnt = 0;
    bit   armed = 1'b0;
    int   snap;

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .P_Data(P_Data), .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Sampler: line delayed one cycle; deserializer: LSB-first shift on deser_en
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit <= 1'b1;
            P_Data      <= '0;
        end else begin
            sampled_bit <= RX_IN;
            if (deser_en) P_Data <= {sampled_bit, P_Data[DW-1:1]};
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: counts deser_en pulses, then scores the frame when it completes
    always @(negedge CLK) begin
        if (!RST) begin
            pulses = 0;
            armed  = 1'b0;
        end else begin
            if (deser_en) begin
                pulse_total++;
                if (pulses > 0 && q.size() > 0) chk("deser_spacing", cyc - last_pulse_cyc, q[0].pre);
                last_pulse_cyc = cyc;
                pulses++;
                if (pulses == DW) begin
                    armed    = 1'b1;
                    wait_cnt = 0;
                end
            end
            if (!armed && data_valid) begin
                checks++;
                errors++;
                $display("FAIL spurious_data_valid: got 1, expected 0 (cycle %0d)", cyc);
            end
            if (armed) begin
                if (data_valid || par_err || stp_err) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: data %0h with no expectation", P_Data);
                    end else begin
                        mon_e = q.pop_front();
                        chk("p_data", int'(P_Data), int'(mon_e.data));
                        chk("par_err", int'(par_err), int'(mon_e.pe));
                        chk("stp_err", int'(stp_err), int'(mon_e.se));
                        chk("data_valid", int'(data_valid), int'(!(mon_e.pe || mon_e.se)));
                        chk("deser_count", pulses, DW);
                        if (data_valid) begin
                            if (mon_e.gap > 0) chk("valid_gap", cyc - last_dv_cyc, mon_e.gap);
                            last_dv_cyc = cyc;
                        end
                    end
                    armed  = 1'b0;
                    pulses = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt > 200) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_timeout: no frame end after %0d cycles", wait_cnt);
                        if (q.size() > 0) void'(q.pop_front());
                        armed  = 1'b0;
                        pulses = 0;
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int pre);
        RX_IN = b;
        repeat (pre) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic se, input int pre, input int gap);
        exp_t e;
        e.data = d; e.pe = pe; e.se = se; e.pre = pre; e.gap = gap;
        q.push_back(e);
    endtask

    // One full frame on the line; scramble changes config inputs mid-frame
    task automatic send_frame(input logic [7:0] d, input int pre, input bit with_par,
                              input bit par_bit, input bit stop_bit, input bit scramble);
        Prescale = 6'(pre);
        RX_IN    = 1'b0;
        @(posedge CLK);
        #1;
        chk("start_edge_cnt", int'(edge_cnt), 0);
        chk("start_samp_en", int'(dat_samp_en), 1);
        chk("start_par_err", int'(par_err), 0);
        chk("start_stp_err", int'(stp_err), 0);
        if (scramble) begin
            Prescale = (pre == 8) ? 6'd16 : 6'd8;
            PAR_EN   = ~PAR_EN;
            PAR_TYP  = ~PAR_TYP;
        end
        repeat (pre - 1) @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) send_bit(d[i], pre);
        if (with_par) send_bit(par_bit, pre);
        send_bit(stop_bit, pre);
        if (scramble) begin
            Prescale = 6'(pre);
            PAR_EN   = ~PAR_EN;
            PAR_TYP  = ~PAR_TYP;
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_samp_en", int'(dat_samp_en), 0);
        chk("rst_deser_en", int'(deser_en), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_par_err", int'(par_err), 0);
        chk("rst_stp_err", int'(stp_err), 0);
        RST = 1'b1;
        idle(5);

        // 0xA5 at Prescale 8, config inputs disturbed mid-frame
        push(8'hA5, 1'b0, 1'b0, 8, 0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("idle_samp_en", int'(dat_samp_en), 0);

        // 3-cycle start glitch at Prescale 16
        Prescale = 6'd16;
        snap  = pulse_total;
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        chk("glitch_samp_en_14", int'(dat_samp_en), 1);
        @(posedge CLK);
        #1;
        chk("glitch_edge_15", int'(edge_cnt), 15);
        @(posedge CLK);
        #1;
        chk("glitch_samp_en_16", int'(dat_samp_en), 0);
        chk("glitch_edge_16", int'(edge_cnt), 0);
        chk("glitch_no_deser", pulse_total - snap, 0);
        chk("glitch_stp_err", int'(stp_err), 0);
        idle(10);

        // 0x81 at Prescale 16 with parity enabled
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
`ifdef UART_RX_PARITY_EN
        push(8'h81, 1'b0, 1'b0, 16, 0);
        send_frame(8'h81, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(20);
        push(8'h81, 1'b1, 1'b0, 16, 0);
        send_frame(8'h81, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(20);
        chk("par_err_hold", int'(par_err), 1);
        PAR_TYP = 1'b1;
        push(8'h81, 1'b0, 1'b0, 16, 0);
        send_frame(8'h81, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(20);
`else
        push(8'h81, 1'b0, 1'b0, 16, 0);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        PAR_TYP = 1'b1;
        push(8'h7E, 1'b0, 1'b0, 16, 0);
        send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
`endif
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;

        // 0x3C at Prescale 32 with a broken stop bit; flag must hold
        push(8'h3C, 1'b0, 1'b1, 32, 0);
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(40);
        chk("stp_err_hold", int'(stp_err), 1);
        chk("stp_err_no_valid", int'(data_valid), 0);

        // Back-to-back 0x55, 0xAA at Prescale 8
        push(8'h55, 1'b0, 1'b0, 8, 0);
        push(8'hAA, 1'b0, 1'b0, 8, 80);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // Illegal Prescale 0 must still return to IDLE once the line is high
        Prescale = 6'd0;
        RX_IN = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        idle(200);
        chk("illegal_pre_idle", int'(dat_samp_en), 0);
        chk("illegal_pre_edge", int'(edge_cnt), 0);

        // Reset during data bit 4, then a clean 0x0F frame
        Prescale = 6'd8;
        RX_IN = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_frame_active", int'(dat_samp_en), 1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("async_rst_edge", int'(edge_cnt), 0);
        chk("async_rst_samp_en", int'(dat_samp_en), 0);
        chk("async_rst_deser", int'(deser_en), 0);
        chk("async_rst_valid", int'(data_valid), 0);
        chk("async_rst_par", int'(par_err), 0);
        chk("async_rst_stp", int'(stp_err), 0);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle(10);
        chk("post_rst_idle", int'(dat_samp_en), 0);
        push(8'h0F, 1'b0, 1'b0, 8, 0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge CLK);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d frames still expected", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
